// File: rtl/reg_writeback.sv
// Register-file writeback buffer: in-order FIFO of pending writes that drains one
// entry per cycle into the register file and forwards the youngest pending value to decode.
module reg_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic                     rf_stall,
    input  logic                     flush,
    output logic [4:0]               rf_wr_addr,
    output logic [31:0]              rf_data_out,
    output logic                     rf_write_enable,
    input  logic [4:0]               chk1_addr,
    input  logic [4:0]               chk2_addr,
    output logic                     chk1_hit,
    output logic                     chk2_hit,
    output logic [31:0]              chk1_data,
    output logic [31:0]              chk2_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] idx;
    logic          accept;
    logic          enq;
    logic          pop;

    // Handshake: a request transfers at a rising edge where wb_valid && wb_ready.
    // wb_ready never looks at wb_valid, and a full buffer refuses even if it pops that edge.
    assign wb_ready = (count < CW'(DEPTH)) && !flush;
    assign accept   = wb_valid && wb_ready;
    assign enq      = accept && (wb_addr != 5'd0);
    assign pop      = (count != '0) && !rf_stall && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: every read of it is qualified by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_addr[wr_ptr] <= wb_addr;
            mem_data[wr_ptr] <= wb_data;
        end
    end

    assign rf_write_enable = (count != '0);
    assign rf_wr_addr      = rf_write_enable ? mem_addr[rd_ptr] : 5'd0;
    assign rf_data_out     = rf_write_enable ? mem_data[rd_ptr] : 32'd0;

    // Walk live entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        chk1_hit  = 1'b0;
        chk1_data = 32'd0;
        chk2_hit  = 1'b0;
        chk2_data = 32'd0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if (CW'(i) < count) begin
                if ((chk1_addr != 5'd0) && (mem_addr[idx] == chk1_addr)) begin
                    chk1_hit  = 1'b1;
                    chk1_data = mem_data[idx];
                end
                if ((chk2_addr != 5'd0) && (mem_addr[idx] == chk2_addr)) begin
                    chk2_hit  = 1'b1;
                    chk2_data = mem_data[idx];
                end
            end
        end
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DEPTH, 4, number of write-request buffer entries (power of two, at least 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 wb_valid  input  1  writeback request present.
REQ-005 wb_ready  output  1  block can accept a request this cycle.
REQ-006 wb_addr  input  5  destination register number.
REQ-007 wb_data  input  32  value to write.
REQ-008 rf_stall  input  1  register file cannot take a write this cycle.
REQ-009 flush  input  1  synchronous discard of all buffered requests.
REQ-010 rf_wr_addr  output  5  register file write address.
REQ-011 rf_data_out  output  32  register file write data.
REQ-012 rf_write_enable  output  1  register file write strobe; 1 = ENABLE.
REQ-013 chk1_addr, chk2_addr  input  5 each  operand addresses being read by decode.
REQ-014 chk1_hit, chk2_hit  output  1 each  a buffered write to that address is pending.
REQ-015 chk1_data, chk2_data  output  32 each  forwarded value for a hit, else 0.
REQ-016 count  output  log2(DEPTH)+1  number of buffered entries.

Function
REQ-017 The block SHALL hold requests in an in-order FIFO of DEPTH entries (5-bit addr, 32-bit data each), with read/write pointers wrapping modulo DEPTH.
REQ-018 wb_ready SHALL equal (count < DEPTH) and not flush; it SHALL NOT depend on wb_valid.
REQ-019 Accept = wb_valid and wb_ready at a rising edge; an accepted request with wb_addr = 0 SHALL be discarded (not enqueued, count unchanged).
REQ-020 rf_write_enable SHALL equal (count != 0); rf_wr_addr/rf_data_out SHALL show the head entry while count != 0, else 0.
REQ-021 The head SHALL be popped at a rising edge when count != 0, rf_stall = 0, and flush = 0.
REQ-022 Latency: a request accepted into an empty buffer at edge N SHALL drive rf_write_enable = 1 during the cycle after edge N.
REQ-023 Simultaneous enqueue and pop SHALL leave count unchanged; a request is never accepted when count = DEPTH, even when a pop occurs in the same cycle.
REQ-024 With rf_stall = 1 the head and all outputs SHALL hold; rf_write_enable stays 1 if count != 0.
REQ-025 chkN_hit SHALL be 1 when chkN_addr != 0 and any buffered entry matches it; chkN_data SHALL be the data of the youngest matching entry; lookups are combinational over buffered entries only (not the wb_* inputs).
REQ-026 chkN_addr = 0 SHALL always give hit = 0, data = 0.
REQ-027 flush = 1 at an edge SHALL set count and both pointers to 0; no pop, no enqueue that edge; rf_write_enable = 0 the next cycle.
REQ-028 Requests SHALL reach the register file in acceptance order, each exactly once.

Reset
REQ-029 While rst = 1: count = 0, pointers = 0, rf_write_enable = 0, rf_wr_addr = 0, rf_data_out = 0, all chk outputs 0, wb_ready = 1 (if flush = 0).
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries immediately, independent of clk; no write is issued after release until a new accept.

Verification
REQ-031 Empty buffer, accept (addr 5, 0x0000_00AA) at edge N -> cycle after N: rf_write_enable = 1, rf_wr_addr = 5, rf_data_out = 0xAA; after edge N+1 count = 0.
REQ-032 rf_stall = 1, accept 4 requests (addr 1..4) -> count = 4, wb_ready = 0; a fifth request is not accepted; release stall -> writes 1,2,3,4 on four consecutive cycles.
REQ-033 Buffer holds (7, 0x11) then (7, 0x22) with stall -> chk1_addr = 7 gives hit = 1, data = 0x22; chk2_addr = 8 gives hit = 0, data = 0.
REQ-034 Accept wb_addr = 0 with data 0xFFFF_FFFF -> count stays 0, rf_write_enable stays 0; chk1_addr = 0 gives hit = 0.
REQ-035 Count = 3 (stalled), flush = 1 for one edge with wb_valid = 1 -> next cycle count = 0, rf_write_enable = 0, input not accepted.
REQ-036 Count = 2, rst pulsed between clock edges -> count = 0 and rf_write_enable = 0 immediately; after release, no writes until a new accept.
